argon_bus_router: RTL and testbench

ARGON_BUS_ROUTER -- requirements
Module: argon_bus_router

---
 rtl/argon_bus_router.sv | 153 +++++++++++++++
 tb/tb_argon_bus_router.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/argon_bus_router.sv
// Single-transfer bus router: fetch a word from one unit, deliver it to another,
// then report completion. One transfer in flight; minimum issue interval of 4 cycles.
module argon_bus_router #(
  parameter int N_UNITS = 4,
  parameter int DATA_W  = 16,
  parameter int CMD_W   = 4,
  parameter int TIMEOUT = 15,
  localparam int ID_W   = ($clog2(N_UNITS) > 1) ? $clog2(N_UNITS) : 1
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic [ID_W-1:0]           i_src_id,
  input  logic [ID_W-1:0]           i_dst_id,
  input  logic [CMD_W-1:0]          i_src_cmd,
  input  logic [CMD_W-1:0]          i_dst_cmd,
  output logic [N_UNITS*CMD_W-1:0]  o_unit_cmd,
  input  logic [N_UNITS*DATA_W-1:0] i_unit_o_data,
  input  logic [N_UNITS-1:0]        i_unit_o_valid,
  output logic [DATA_W-1:0]         o_unit_i_data,
  output logic [N_UNITS-1:0]        o_unit_i_valid,
  output logic                      o_done,
  output logic                      o_error,
  output logic [DATA_W-1:0]         o_data,
  output logic                      o_busy
);

  typedef enum logic [1:0] {IDLE, FETCH, DELIVER, RESP} state_t;

  state_t             state, state_nx;
  logic [7:0]         cnt, cnt_nx;
  logic [DATA_W-1:0]  hold, hold_nx;
  logic               err, err_nx;
  logic [ID_W-1:0]    src_r, dst_r;
  logic [CMD_W-1:0]   src_cmd_r, dst_cmd_r;
  logic               accept, bad_id;
  logic               src_valid;
  logic [DATA_W-1:0]  src_data;

  assign accept = (state == IDLE) && i_req_valid;
  assign bad_id = (int'(i_src_id) >= N_UNITS) || (int'(i_dst_id) >= N_UNITS);

  always_comb begin
    src_valid = 1'b0;
    src_data  = '0;
    for (int u = 0; u < N_UNITS; u++) begin
      if (ID_W'(u) == src_r) begin
        src_valid = i_unit_o_valid[u];
        src_data  = i_unit_o_data[u*DATA_W +: DATA_W];
      end else begin
        src_valid = src_valid;
        src_data  = src_data;
      end
    end
  end

  // A valid seen on the cycle the counter hits TIMEOUT takes priority over the timeout.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    hold_nx  = hold;
    err_nx   = err;
    case (state)
      IDLE: begin
        if (i_req_valid) begin
          if (bad_id) begin
            state_nx = RESP;
            err_nx   = 1'b1;
          end else begin
            state_nx = FETCH;
            cnt_nx   = 8'd0;
            err_nx   = 1'b0;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      FETCH: begin
        if (src_valid) begin
          hold_nx  = src_data;
          state_nx = DELIVER;
        end else if (cnt == 8'(TIMEOUT)) begin
          state_nx = RESP;
          err_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      DELIVER: begin
        state_nx = RESP;
        err_nx   = 1'b0;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      hold      <= '0;
      err       <= 1'b0;
      src_r     <= '0;
      dst_r     <= '0;
      src_cmd_r <= '0;
      dst_cmd_r <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      hold  <= hold_nx;
      err   <= err_nx;
      if (accept) begin
        src_r     <= i_src_id;
        dst_r     <= i_dst_id;
        src_cmd_r <= i_src_cmd;
        dst_cmd_r <= i_dst_cmd;
      end
    end
  end

  // Unit-side outputs decode from registered state only, so they are glitch-free.
  always_comb begin
    o_unit_cmd     = '0;
    o_unit_i_valid = '0;
    o_unit_i_data  = '0;
    case (state)
      FETCH: begin
        for (int u = 0; u < N_UNITS; u++) begin
          o_unit_cmd[u*CMD_W +: CMD_W] = (ID_W'(u) == src_r) ? src_cmd_r : '0;
        end
      end
      DELIVER: begin
        o_unit_i_data = hold;
        for (int u = 0; u < N_UNITS; u++) begin
          o_unit_cmd[u*CMD_W +: CMD_W] = (ID_W'(u) == dst_r) ? dst_cmd_r : '0;
          o_unit_i_valid[u]            = (ID_W'(u) == dst_r);
        end
      end
      default: begin
        o_unit_cmd = '0;
      end
    endcase
  end

  assign o_req_ready = (state == IDLE);
  assign o_busy      = (state != IDLE);
  assign o_done      = (state == RESP);
  assign o_error     = (state == RESP) && err;
  assign o_data      = hold;

endmodule

// File: tb/tb_argon_bus_router.sv
// Directed bench for argon_bus_router: a 4-unit instance for the main flows and a
// 3-unit instance for out-of-range ids.
module tb_argon_bus_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  src_id, dst_id;
  logic [3:0]  src_cmd, dst_cmd;
  logic [15:0] unit_cmd;
  logic [15:0] u_data [4];
  logic [63:0] unit_o_data;
  logic [3:0]  unit_o_valid;
  logic [15:0] unit_i_data;
  logic [3:0]  unit_i_valid;
  logic        done, error, busy;
  logic [15:0] data;

  logic        r3_req_valid, r3_req_ready;
  logic [1:0]  r3_src_id, r3_dst_id;
  logic [11:0] r3_unit_cmd;
  logic [2:0]  r3_unit_i_valid;
  logic [15:0] r3_unit_i_data, r3_data;
  logic        r3_done, r3_error, r3_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int acc_cyc [3];
  logic [1:0] acc_src [3];
  logic [1:0] acc_dst [3];
  int n_acc, n_del;

  assign unit_o_data = {u_data[3], u_data[2], u_data[1], u_data[0]};

  always #5 clk = ~clk;

  argon_bus_router #(.N_UNITS(4), .DATA_W(16), .CMD_W(4), .TIMEOUT(15)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_src_id(src_id), .i_dst_id(dst_id), .i_src_cmd(src_cmd), .i_dst_cmd(dst_cmd),
    .o_unit_cmd(unit_cmd), .i_unit_o_data(unit_o_data), .i_unit_o_valid(unit_o_valid),
    .o_unit_i_data(unit_i_data), .o_unit_i_valid(unit_i_valid), .o_done(done),
    .o_error(error), .o_data(data), .o_busy(busy)
  );

  argon_bus_router #(.N_UNITS(3), .DATA_W(16), .CMD_W(4), .TIMEOUT(15)) dut3 (
    .i_Clk(clk), .i_Reset(rst), .i_req_valid(r3_req_valid), .o_req_ready(r3_req_ready),
    .i_src_id(r3_src_id), .i_dst_id(r3_dst_id), .i_src_cmd(4'hF), .i_dst_cmd(4'hE),
    .o_unit_cmd(r3_unit_cmd), .i_unit_o_data(48'h222211110000), .i_unit_o_valid(3'b111),
    .o_unit_i_data(r3_unit_i_data), .o_unit_i_valid(r3_unit_i_valid), .o_done(r3_done),
    .o_error(r3_error), .o_data(r3_data), .o_busy(r3_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; src_id = 2'd0; dst_id = 2'd0;
    src_cmd = 4'd0; dst_cmd = 4'd0; unit_o_valid = 4'b0000;
    u_data[0] = 16'h1111; u_data[1] = 16'h1234; u_data[2] = 16'h3333; u_data[3] = 16'h4444;
    r3_req_valid = 1'b0; r3_src_id = 2'd0; r3_dst_id = 2'd0;
    tick(); tick();
    chk("rst_ready", req_ready, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_error", error, 0); chk("rst_data", data, 0); chk("rst_cmd", unit_cmd, 0);
    chk("rst_ivalid", unit_i_valid, 0); chk("rst_idata", unit_i_data, 0);
    chk("rst3_ready", r3_req_ready, 1);
    rst = 1'b0;

    // Basic transfer unit1 -> unit2, source already valid
    src_id = 2'd1; dst_id = 2'd2; src_cmd = 4'h3; dst_cmd = 4'h5;
    unit_o_valid = 4'b0010; req_valid = 1'b1;
    tick();
    chk("t1_fetch_cmd", unit_cmd, 16'h0030); chk("t1_fetch_ready", req_ready, 0);
    chk("t1_fetch_busy", busy, 1);
    req_valid = 1'b0; src_id = 2'd3; dst_id = 2'd0; src_cmd = 4'h9; dst_cmd = 4'h9;
    tick();
    chk("t1_dlv_valid", unit_i_valid, 4'b0100); chk("t1_dlv_data", unit_i_data, 16'h1234);
    chk("t1_dlv_cmd", unit_cmd, 16'h0500); chk("t1_dlv_done", done, 0);
    tick();
    chk("t1_resp_done", done, 1); chk("t1_resp_error", error, 0);
    chk("t1_resp_data", data, 16'h1234); chk("t1_resp_ivalid", unit_i_valid, 0);
    chk("t1_resp_cmd", unit_cmd, 0); chk("t1_resp_ready", req_ready, 0);
    tick();
    chk("t1_idle_done", done, 0); chk("t1_idle_ready", req_ready, 1);

    // Timeout: source never valid, RESP 16 edges after the accept edge
    unit_o_valid = 4'b0000; src_id = 2'd0; dst_id = 2'd3; src_cmd = 4'h7; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("t2_fetch_cmd", unit_cmd, 16'h0007);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk($sformatf("t2_wait%0d_done", i), done, 0);
      chk($sformatf("t2_wait%0d_ivalid", i), unit_i_valid, 0);
    end
    tick();
    chk("t2_resp_done", done, 1); chk("t2_resp_error", error, 1);
    chk("t2_resp_data", data, 16'h1234);
    tick();
    chk("t2_idle_ready", req_ready, 1);

    // Valid arrives on the exact timeout cycle: success
    src_id = 2'd2; dst_id = 2'd0; dst_cmd = 4'hA; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 1; i <= 15; i++) tick();
    chk("t3_still_fetch", busy & ~done, 1);
    unit_o_valid = 4'b0100;
    tick();
    unit_o_valid = 4'b0000;
    chk("t3_dlv_valid", unit_i_valid, 4'b0001); chk("t3_dlv_data", unit_i_data, 16'h3333);
    chk("t3_dlv_cmd", unit_cmd, 16'h000A);
    tick();
    chk("t3_resp_done", done, 1); chk("t3_resp_error", error, 0);
    chk("t3_resp_data", data, 16'h3333);
    tick();

    // Reset during FETCH aborts, then a normal transfer
    src_id = 2'd1; dst_id = 2'd0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("t4_in_fetch", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_rst_ready", req_ready, 1); chk("t4_rst_done", done, 0);
    chk("t4_rst_data", data, 0); chk("t4_rst_cmd", unit_cmd, 0);
    tick();
    chk("t4_after_done", done, 0); chk("t4_after_ivalid", unit_i_valid, 0);
    src_id = 2'd3; dst_id = 2'd1; unit_o_valid = 4'b1000; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("t4_dlv_valid", unit_i_valid, 4'b0010); chk("t4_dlv_data", unit_i_data, 16'h4444);
    tick();
    chk("t4_resp_done", done, 1); chk("t4_resp_error", error, 0);
    chk("t4_resp_data", data, 16'h4444);
    tick();

    // Back-to-back: request held high, ids change every cycle
    u_data[0] = 16'hA0A0; u_data[1] = 16'hB1B1; u_data[2] = 16'hC2C2; u_data[3] = 16'hD3D3;
    unit_o_valid = 4'b1111; req_valid = 1'b1; n_acc = 0; n_del = 0;
    for (int c = 0; c < 12; c++) begin
      src_id = 2'(c + c / 4);
      dst_id = 2'(c / 4 + 3 * c);
      src_cmd = 4'(c); dst_cmd = 4'(c + 1);
      if (req_ready) begin
        if (n_acc < 3) begin
          acc_cyc[n_acc] = c; acc_src[n_acc] = src_id; acc_dst[n_acc] = dst_id;
        end
        n_acc++;
      end
      tick();
      if (unit_i_valid != 4'b0000 && n_acc >= 1 && n_acc <= 3) begin
        n_del++;
        chk($sformatf("t5_dlv%0d_valid", n_del), unit_i_valid, 4'b0001 << acc_dst[n_acc-1]);
        chk($sformatf("t5_dlv%0d_data", n_del), unit_i_data, u_data[acc_src[n_acc-1]]);
      end
    end
    req_valid = 1'b0; unit_o_valid = 4'b0000;
    chk("t5_accepts", n_acc, 3); chk("t5_delivers", n_del, 3);
    chk("t5_gap1", acc_cyc[1] - acc_cyc[0], 4); chk("t5_gap2", acc_cyc[2] - acc_cyc[1], 4);
    tick();

    // Out-of-range ids on a 3-unit router
    r3_src_id = 2'd3; r3_dst_id = 2'd1; r3_req_valid = 1'b1;
    chk("t6_pre_cmd", r3_unit_cmd, 0);
    tick();
    r3_req_valid = 1'b0;
    chk("t6_resp_done", r3_done, 1); chk("t6_resp_error", r3_error, 1);
    chk("t6_resp_cmd", r3_unit_cmd, 0); chk("t6_resp_ivalid", r3_unit_i_valid, 0);
    tick();
    chk("t6_idle_done", r3_done, 0); chk("t6_idle_cmd", r3_unit_cmd, 0);
    r3_src_id = 2'd0; r3_dst_id = 2'd3; r3_req_valid = 1'b1;
    tick();
    r3_req_valid = 1'b0;
    chk("t6b_resp_done", r3_done, 1); chk("t6b_resp_error", r3_error, 1);
    chk("t6b_resp_cmd", r3_unit_cmd, 0); chk("t6b_data", r3_data, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
